// File: rtl/dft_sequencer.sv
// dft_sequencer: frame controller for the 16-lane DFT multiply-accumulate
// datapath. It captures one frame of time samples over a valid/ready
// handshake, then walks every harmonic group across every time index. Each
// step is a fixed multiply window, then an add window, then one accumulator
// write. All outputs except cap_we are registered.
module dft_sequencer #(
  parameter int N_SAMPLES = 128,
  parameter int N_LANES   = 16,
  parameter int MUL_LAT   = 4,
  parameter int ADD_LAT   = 5,
  localparam int N_GROUPS = N_SAMPLES / N_LANES,
  localparam int AW       = $clog2(N_SAMPLES),
  localparam int GW       = $clog2(N_GROUPS),
  localparam int LW       = $clog2(N_LANES),
  localparam int MAX_LAT  = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT,
  localparam int CW       = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  input  logic          abort,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          cap_we,
  output logic [AW-1:0] cap_addr,
  output logic [GW-1:0] bank,
  output logic [AW-1:0] time_idx,
  output logic          mul_en,
  output logic          add_en,
  output logic          acc_clear,
  output logic          acc_we,
  output logic [AW-1:0] acc_base,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MUL,
    S_ADD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] cap_addr_d, time_idx_d, acc_base_d;
  logic [GW-1:0] bank_d;
  logic          sample_ready_d, mul_en_d, add_en_d, acc_clear_d;
  logic          acc_we_d, busy_d, done_d;

  // The only combinational output: a sample is written when both sides agree.
  assign cap_we = sample_valid & sample_ready;

  // State, counters and registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cap_addr     <= '0;
      bank         <= '0;
      time_idx     <= '0;
      acc_base     <= '0;
      sample_ready <= 1'b0;
      mul_en       <= 1'b0;
      add_en       <= 1'b0;
      acc_clear    <= 1'b0;
      acc_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      cap_addr     <= cap_addr_d;
      bank         <= bank_d;
      time_idx     <= time_idx_d;
      acc_base     <= acc_base_d;
      sample_ready <= sample_ready_d;
      mul_en       <= mul_en_d;
      add_en       <= add_en_d;
      acc_clear    <= acc_clear_d;
      acc_we       <= acc_we_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state and counter sequencing. The registered outputs are decoded
  // from the next state so that they line up with the state they describe.
  // NOTE: every signal gets a default first so no path leaves a value
  // unassigned, which would infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cap_addr_d = cap_addr;
    bank_d     = bank;
    time_idx_d = time_idx;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_CAPTURE;
          cap_addr_d = '0;
        end
      end
      S_CAPTURE: begin
        if (cap_we) begin
          cap_addr_d = cap_addr + AW'(1);
          if (cap_addr == AW'(N_SAMPLES - 1)) begin
            state_d    = S_MUL;
            bank_d     = '0;
            time_idx_d = '0;
            cnt_d      = '0;
          end
        end
      end
      S_MUL: begin
        if (cnt == CW'(MUL_LAT - 1)) begin
          state_d = S_ADD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_ADD: begin
        if (cnt == CW'(ADD_LAT - 1)) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_WRITE: begin
        cnt_d = '0;
        if (time_idx != AW'(N_SAMPLES - 1)) begin
          time_idx_d = time_idx + AW'(1);
          state_d    = S_MUL;
        end else if (bank != GW'(N_GROUPS - 1)) begin
          time_idx_d = '0;
          bank_d     = bank + GW'(1);
          state_d    = S_MUL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        bank_d     = '0;
        time_idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over any sequencing decided above; the current cycle's
    // registered strobes (including an acc_we) still complete.
    if (abort && state != S_IDLE) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      cap_addr_d = '0;
      bank_d     = '0;
      time_idx_d = '0;
    end

    sample_ready_d = (state_d == S_CAPTURE);
    mul_en_d       = (state_d == S_MUL);
    add_en_d       = (state_d == S_ADD);
    acc_clear_d    = (state_d == S_ADD) && (time_idx_d == '0);
    acc_we_d       = (state_d == S_WRITE);
    done_d         = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
    acc_base_d     = {bank_d, {LW{1'b0}}};
  end

endmodule

// File: tb/tb_dft_sequencer.sv
// tb_dft_sequencer: randomized bench for dft_sequencer. A frame-level model
// (capture count, compute cycle number) predicts every output each cycle.
module tb_dft_sequencer;

  localparam int NS    = 128;
  localparam int NL    = 16;
  localparam int ML    = 4;
  localparam int AL    = 5;
  localparam int NG    = NS / NL;
  localparam int STEP  = ML + AL + 1;
  localparam int TOTAL = NG * NS * STEP;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready, cap_we, mul_en, add_en, acc_clear, acc_we, busy, done;
  logic [6:0] cap_addr, time_idx, acc_base;
  logic [2:0] bank;

  dft_sequencer #(
    .N_SAMPLES(NS), .N_LANES(NL), .MUL_LAT(ML), .ADD_LAT(AL)
  ) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .cap_we(cap_we),
    .cap_addr(cap_addr), .bank(bank), .time_idx(time_idx), .mul_en(mul_en),
    .add_en(add_en), .acc_clear(acc_clear), .acc_we(acc_we),
    .acc_base(acc_base), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {sample_ready, cap_we, mul_en, add_en, acc_clear, acc_we,
                busy, done, bank, time_idx, cap_addr};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: 0 idle, 1 capturing, 2 computing, 3 done pulse.
  int m_mode = 0;
  int m_acc  = 0;
  int m_c    = 0;

  function automatic logic [24:0] expect_vec(input logic v);
    logic sr, cw, me, ae, ac, aw, bs, dn;
    int bk, ti, ca, step, ph;
    {sr, cw, me, ae, ac, aw, bs, dn} = '0;
    bk = 0; ti = 0; ca = 0;
    case (m_mode)
      1: begin
        sr = 1'b1; cw = v; ca = m_acc % NS; bs = 1'b1;
      end
      2: begin
        step = m_c / STEP;
        ph   = m_c % STEP;
        bk   = step / NS;
        ti   = step % NS;
        me   = (ph < ML);
        ae   = (ph >= ML) && (ph < ML + AL);
        aw   = (ph == STEP - 1);
        ac   = ae && (ti == 0);
        bs   = 1'b1;
      end
      3: begin
        dn = 1'b1; bs = 1'b1; bk = NG - 1; ti = NS - 1;
      end
      default: ;
    endcase
    return {sr, cw, me, ae, ac, aw, bs, dn, 3'(bk), 7'(ti), 7'(ca)};
  endfunction

  // One clock cycle: drive after the edge, check at the falling edge, then
  // advance the model by what the next rising edge should do.
  task automatic cycle(input logic st, input logic ab, input logic v);
    @(posedge clk);
    #1;
    start = st; abort = ab; sample_valid = v;
    @(negedge clk);
    check("cyc", 32'(obs), 32'(expect_vec(v)));
    if (m_mode == 2 && (m_c % STEP) == STEP - 1)
      check("acc_base", 32'(acc_base), 32'((m_c / STEP / NS) * NL));
    if (m_mode == 0) begin
      if (st && !ab) begin m_mode = 1; m_acc = 0; end
    end else if (ab) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        1: if (v) begin
             m_acc++;
             if (m_acc == NS) begin m_mode = 2; m_c = 0; end
           end
        2: begin
             m_c++;
             if (m_c == TOTAL) m_mode = 3;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  // vmode: 0 back-to-back, 1 alternating 1,0,1,0, 2 random 70% valid.
  task automatic frame(input int vmode, input int abort_c, input int abort_acc, input int reset_c);
    int   k;
    logic t, v, ab, st, was_cap;
    cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    k = 0;
    t = 1'b1;
    while (m_mode != 0 && k < 20000) begin
      if (m_mode == 1) begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = t;
          default: v = ($urandom_range(0, 9) < 7);
        endcase
      end else begin
        v = 1'($urandom_range(0, 1));
      end
      if (m_mode == 2 && m_c == reset_c) begin
        @(posedge clk);
        #2;
        check("pre_reset_add_en", 32'(add_en), 32'd1);
        #1;
        n_reset = 1'b0;
        #1;
        check("reset_obs", 32'(obs), 32'd0);
        check("reset_base", 32'(acc_base), 32'd0);
        m_mode = 0;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        return;
      end
      ab = (m_mode == 2 && m_c == abort_c) || (m_mode == 1 && m_acc == abort_acc && v);
      st = ($urandom_range(0, 7) == 0);
      was_cap = (m_mode == 1);
      cycle(st, ab, v);
      if (was_cap) t = ~t;
      k++;
    end
    if (k >= 20000) check("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_obs", 32'(obs), 32'd0);
    check("rst_base", 32'(acc_base), 32'd0);
    n_reset = 1'b1;

    frame(0, -1, -1, -1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    frame(1, -1, -1, -1);
    frame(2, 5000, -1, -1);
    // abort together with start in idle keeps the sequencer idle
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    frame(2, -1, 50, -1);
    frame(0, -1, -1, 3 * STEP + 6);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    frame(2, 1000, -1, -1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dft_sequencer.md
Name: dft_sequencer

Overview:
- Control sequencer for the 16-lane DFT multiply-accumulate datapath (FPMul/FPAdd lanes, 128-entry cos/sin accumulator banks).
- Captures 128 time samples through a valid/ready handshake.
- Steps the datapath through 8 harmonic groups x 128 time indices with explicit multiplier/adder clock-enable windows, accumulator write strobes and a done pulse.
- Replaces ad-hoc clock-level enable generation with a single posedge-clk FSM.

Parameters:
- N_SAMPLES, 128, time samples per frame and harmonics computed; power of two.
- N_LANES, 16, parallel MAC lanes; N_SAMPLES divisible by N_LANES.
- MUL_LAT, 4, cycles mul_en held per step (FPMul latency); >=1.
- ADD_LAT, 5, cycles add_en held per step (FPAdd latency); >=1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle, no done.
- sample_valid  in  1  time sample present on the external data bus.
- sample_ready  out  1  sequencer accepts a sample this cycle.
- cap_we  out  1  write strobe to the time-sample store (= sample_valid & sample_ready).
- cap_addr  out  7  time-sample store address for cap_we.
- bank  out  3  harmonic group; selects the cos_in/sin_in coefficient set.
- time_idx  out  7  time sample index fed to the multipliers.
- mul_en  out  1  clock enable for all FPMul lanes.
- add_en  out  1  clock enable for all FPAdd lanes.
- acc_clear  out  1  adders use 0 instead of the stored accumulator (first term).
- acc_we  out  1  write the lane sums into cos/sin accumulator entries acc_base..acc_base+15.
- acc_base  out  7  bank*N_LANES.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: state IDLE; sample_ready, cap_we, mul_en, add_en, acc_clear, acc_we, busy, done = 0; cap_addr, bank, time_idx, acc_base = 0.
- Derived constants: N_GROUPS = N_SAMPLES/N_LANES = 8. All outputs are registered except cap_we (combinational AND).
- IDLE: on start=1, go to CAPTURE with cap_addr=0. start is ignored in every other state.
- CAPTURE:
  - sample_ready=1.
  - Each cycle with sample_valid=1: cap_we=1 and cap_addr increments.
  - After address N_SAMPLES-1 is written, go to MUL with bank=0, time_idx=0. sample_ready drops the cycle after the last accept.
  - Gaps in sample_valid stall capture indefinitely.
- MUL: mul_en=1 for exactly MUL_LAT consecutive cycles, then go to ADD.
- ADD: add_en=1 for exactly ADD_LAT cycles; acc_clear=1 throughout when time_idx==0, else 0. Then go to WRITE.
- WRITE: acc_we=1 for one cycle with acc_base=bank*N_LANES. Then:
  - if time_idx<N_SAMPLES-1: time_idx++, go to MUL;
  - else if bank<N_GROUPS-1: time_idx=0, bank++, go to MUL;
  - else go to DONE.
- DONE: done=1 for one cycle, then IDLE. On entry to IDLE: bank=0, time_idx=0.
- Exclusivity and hold:
  - mul_en, add_en and acc_we are mutually exclusive; never two high in the same cycle.
  - bank and time_idx are stable from first mul_en through acc_we of a step.
- Cycle counts:
  - Per step: MUL_LAT+ADD_LAT+1 = 10 cycles.
  - Compute phase: N_GROUPS*N_SAMPLES*10 = 10240 cycles.
  - First mul_en: the cycle after the final capture accept.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with all strobes 0 and counters cleared. No done.
  - An acc_we already in progress that cycle still completes.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, stay IDLE.
- Asynchronous reset mid-frame: immediate return to reset values. A partially written accumulator is not flagged; software restarts.
- Wrap-around: time_idx and cap_addr wrap naturally at N_SAMPLES; bank never exceeds N_GROUPS-1.

Test Plan:
- Reset, start=1 one cycle, 128 back-to-back samples -> cap_we on 128 cycles with cap_addr 0..127; first mul_en one cycle later; done pulse exactly 10240 cycles after first mul_en; busy falls with done.
- Capture with sample_valid toggling 1,0,1,0 -> cap_addr advances only on valid cycles; 256 cycles to fill; no mul_en before the 128th accept.
- Monitor step (bank=2, time_idx=0) -> mul_en 4 cycles, add_en 5 cycles with acc_clear=1, acc_we 1 cycle with acc_base=32; step time_idx=1 -> acc_clear=0.
- Transition bank 0 -> 1 -> after acc_we at time_idx=127, next mul_en has bank=1, time_idx=0, acc_base=16.
- abort at compute cycle 5000 -> IDLE next cycle, no done; a new start restarts capture at cap_addr=0.
- n_reset asserted mid-ADD -> all outputs 0 immediately; start=1 pressed during busy has no effect (no second frame).
